// File: rtl/maxp_unit_if.sv
// maxp_unit_if: stream/result bundle between the pooling controller and maxp_unit.
//   master side (controller / bench): drives start, base_addr, n_out, relu_en,
//                                     unit_en, din, win_last; observes the results.
//   slave side  (maxp_unit):          consumes the stream; drives dout, dout_addr,
//                                     unit_we, busy, err.
interface maxp_unit_if #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 16
);
  logic                 start;
  logic [ADDR_SIZE-1:0] base_addr;
  logic [ADDR_SIZE-1:0] n_out;
  logic                 relu_en;
  logic                 unit_en;
  logic [DATA_SIZE-1:0] din;
  logic                 win_last;
  logic [DATA_SIZE-1:0] dout;
  logic [ADDR_SIZE-1:0] dout_addr;
  logic                 unit_we;
  logic                 busy;
  logic                 err;

  modport master (
    output start, base_addr, n_out, relu_en, unit_en, din, win_last,
    input  dout, dout_addr, unit_we, busy, err
  );

  modport slave (
    input  start, base_addr, n_out, relu_en, unit_en, din, win_last,
    output dout, dout_addr, unit_we, busy, err
  );
endinterface

// File: rtl/maxp_unit.sv
// maxp_unit: max-pool datapath stage. Reduces each window of the element stream
// (qualified by unit_en, closed by win_last) to its signed maximum, optionally
// clamps negatives to zero, and writes one result per window to consecutive
// output-buffer addresses.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - maxp_unit_if.slave: layer setup (start, base_addr, n_out, relu_en),
//          element stream (unit_en, din, win_last) and results
//          (dout, dout_addr, unit_we, busy, err)
module maxp_unit #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 16
) (
  input  logic        clk,
  input  logic        rst,
  maxp_unit_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t                       state_r;
  logic signed [DATA_SIZE-1:0]  acc_r;
  logic                         first_r;
  logic        [ADDR_SIZE-1:0]  cnt_r;
  logic        [ADDR_SIZE-1:0]  n_out_r;
  logic        [ADDR_SIZE-1:0]  addr_r;
  logic                         relu_r;
  logic signed [DATA_SIZE-1:0]  dout_r;
  logic        [ADDR_SIZE-1:0]  dout_addr_r;
  logic                         unit_we_r;
  logic                         busy_r;
  logic                         err_r;

  logic signed [DATA_SIZE-1:0]  din_s;
  logic signed [DATA_SIZE-1:0]  max_s;
  logic signed [DATA_SIZE-1:0]  res_s;
  logic        [ADDR_SIZE-1:0]  cnt_next_s;
  logic                         last_win_s;

  // Signed maximum; on a tie the accumulator value is kept.
  function automatic logic signed [DATA_SIZE-1:0] signed_max(
    input logic signed [DATA_SIZE-1:0] a,
    input logic signed [DATA_SIZE-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  // Running maximum including the current element, relu result and window count.
  always_comb begin
    din_s      = bus.din;
    max_s      = first_r ? din_s : signed_max(acc_r, din_s);
    res_s      = (relu_r && max_s[DATA_SIZE-1]) ? {DATA_SIZE{1'b0}} : max_s;
    cnt_next_s = cnt_r + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
    last_win_s = (cnt_next_s == n_out_r);
  end

  // Control FSM and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      acc_r       <= {DATA_SIZE{1'b0}};
      first_r     <= 1'b0;
      cnt_r       <= {ADDR_SIZE{1'b0}};
      n_out_r     <= {ADDR_SIZE{1'b0}};
      addr_r      <= {ADDR_SIZE{1'b0}};
      relu_r      <= 1'b0;
      dout_r      <= {DATA_SIZE{1'b0}};
      dout_addr_r <= {ADDR_SIZE{1'b0}};
      unit_we_r   <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      unit_we_r <= 1'b0;
      if (bus.start) begin
        // start wins over any element in the same cycle; a partial window is discarded.
        addr_r  <= bus.base_addr;
        n_out_r <= bus.n_out;
        relu_r  <= bus.relu_en;
        cnt_r   <= {ADDR_SIZE{1'b0}};
        first_r <= 1'b1;
        err_r   <= 1'b0;
        if (bus.n_out != {ADDR_SIZE{1'b0}}) begin
          state_r <= ST_ACC;
          busy_r  <= 1'b1;
        end else begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            busy_r <= 1'b0;
            if (bus.unit_en) begin
              err_r <= 1'b1;
            end
          end
          ST_ACC: begin
            if (bus.unit_en) begin
              if (bus.win_last) begin
                unit_we_r   <= 1'b1;
                dout_r      <= res_s;
                dout_addr_r <= addr_r;
                addr_r      <= addr_r + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
                cnt_r       <= cnt_next_s;
                first_r     <= 1'b1;
                if (last_win_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end
              end else begin
                acc_r   <= max_s;
                first_r <= 1'b0;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout      = dout_r;
  assign bus.dout_addr = dout_addr_r;
  assign bus.unit_we   = unit_we_r;
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_maxp_unit.sv
// tb_maxp_unit: scenario tasks for maxp_unit, checked against a window-maximum
// reference computed from plain integer arithmetic.
module tb_maxp_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxp_unit_if #(.DATA_SIZE(16), .ADDR_SIZE(16)) bus();
  maxp_unit #(.DATA_SIZE(16), .ADDR_SIZE(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] d;
    logic [15:0] a;
    logic        b;
    int          c;
  } wr_t;
  wr_t cap[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe with its data, address, busy and cycle.
  always @(negedge clk) begin
    if (bus.unit_we === 1'b1) cap.push_back('{bus.dout, bus.dout_addr, bus.busy, cyc});
  end

  function automatic logic [15:0] ref_max(input int v[8], input int len, input bit relu);
    int m;
    m = v[0];
    for (int i = 1; i < len; i++) if (v[i] > m) m = v[i];
    if (relu && m < 0) m = 0;
    return 16'(m);
  endfunction

  task automatic drive(input logic s, input logic en, input logic [15:0] d, input logic wl);
    @(negedge clk);
    bus.start = s; bus.unit_en = en; bus.din = d; bus.win_last = wl;
  endtask

  task automatic arm(input logic [15:0] base, input logic [15:0] n, input logic relu);
    bus.base_addr = base; bus.n_out = n; bus.relu_en = relu;
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic send_window(input int v[8], input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 2) == 0)
        drive(1'b0, 1'b0, 16'($urandom), 1'($urandom_range(0, 1)));
      drive(1'b0, 1'b1, 16'(v[i]), (i == len - 1));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.unit_en = 1'b0; bus.din = 16'h0; bus.win_last = 1'b0;
    bus.base_addr = 16'h0; bus.n_out = 16'h0; bus.relu_en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.dout, bus.dout_addr, bus.unit_we, bus.busy, bus.err} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.dout, bus.dout_addr, bus.unit_we, bus.busy, bus.err});
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_t1();
    int close_c;
    cap.delete();
    arm(16'h0010, 16'd1, 1'b0);
    drive(1'b0, 1'b1, 16'd3, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_after_start: got %b expected 1", bus.busy); end
    drive(1'b0, 1'b1, -16'sd7, 1'b0);
    drive(1'b0, 1'b1, 16'd12, 1'b0);
    drive(1'b0, 1'b1, 16'd5, 1'b1);
    close_c = cyc;
    repeat (2) drive(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (cap.size() != 1) begin n_fail++; $display("FAIL t1_write_count: got %0d expected 1", cap.size()); end
    else begin
      n_checks++;
      if (cap[0].d !== 16'd12 || cap[0].a !== 16'h0010 || cap[0].b !== 1'b0 || cap[0].c != close_c + 1) begin
        n_fail++;
        $display("FAIL t1_write: got d=%h a=%h busy=%b cyc=%0d expected d=000c a=0010 busy=0 cyc=%0d",
                 cap[0].d, cap[0].a, cap[0].b, cap[0].c, close_c + 1);
      end
    end
  endtask

  task automatic test_relu();
    int w[8];
    logic [15:0] exp_d;
    w = '{-4, -9, -2, -8, 0, 0, 0, 0};
    for (int r = 0; r < 2; r++) begin
      cap.delete();
      arm(16'h0030, 16'd1, 1'(r));
      send_window(w, 4, 1'b0);
      repeat (2) drive(1'b0, 1'b0, 16'h0, 1'b0);
      exp_d = ref_max(w, 4, 1'(r));
      n_checks++;
      if (cap.size() != 1 || cap[0].d !== exp_d) begin
        n_fail++;
        $display("FAIL relu_%0d: got n=%0d d=%h expected n=1 d=%h", r, cap.size(),
                 (cap.size() > 0) ? cap[0].d : 16'hxxxx, exp_d);
      end
    end
  endtask

  task automatic test_back_to_back();
    int close_c;
    cap.delete();
    arm(16'h0100, 16'd3, 1'b0);
    drive(1'b0, 1'b1, 16'd7, 1'b1);
    close_c = cyc;
    drive(1'b0, 1'b1, 16'd8, 1'b1);
    drive(1'b0, 1'b1, 16'd9, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (cap.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", cap.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (cap[i].d !== 16'(7 + i) || cap[i].a !== 16'(16'h0100 + i) ||
            cap[i].b !== (i != 2) || cap[i].c != close_c + 1 + i) begin
          n_fail++;
          $display("FAIL b2b_write%0d: got d=%h a=%h busy=%b cyc=%0d expected d=%h a=%h busy=%b cyc=%0d",
                   i, cap[i].d, cap[i].a, cap[i].b, cap[i].c, 16'(7 + i), 16'(16'h0100 + i),
                   (i != 2), close_c + 1 + i);
        end
      end
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b expected 0", bus.busy); end
  endtask

  task automatic test_wrap();
    cap.delete();
    arm(16'hFFFF, 16'd2, 1'b0);
    drive(1'b0, 1'b1, 16'd5, 1'b0);
    drive(1'b0, 1'b0, 16'd99, 1'b1);
    drive(1'b0, 1'b1, 16'd2, 1'b1);
    drive(1'b0, 1'b0, 16'd0, 1'b0);
    drive(1'b0, 1'b1, -16'sd3, 1'b0);
    drive(1'b0, 1'b0, 16'd500, 1'b0);
    drive(1'b0, 1'b1, -16'sd1, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (cap.size() != 2 || cap[0].d !== 16'd5 || cap[0].a !== 16'hFFFF ||
        cap[1].d !== 16'hFFFF || cap[1].a !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap: got n=%0d w0=%h@%h w1=%h@%h expected n=2 w0=0005@ffff w1=ffff@0000",
               cap.size(), (cap.size() > 0) ? cap[0].d : 16'hx, (cap.size() > 0) ? cap[0].a : 16'hx,
               (cap.size() > 1) ? cap[1].d : 16'hx, (cap.size() > 1) ? cap[1].a : 16'hx);
    end
  endtask

  task automatic test_abort();
    cap.delete();
    arm(16'h0200, 16'd1, 1'b0);
    drive(1'b0, 1'b1, 16'd100, 1'b0);
    drive(1'b0, 1'b1, 16'd50, 1'b0);
    bus.base_addr = 16'h0020; bus.n_out = 16'd1; bus.relu_en = 1'b0;
    drive(1'b1, 1'b1, 16'd200, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 16'd1, (i == 3));
    repeat (2) drive(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (cap.size() != 1 || cap[0].d !== 16'd1 || cap[0].a !== 16'h0020) begin
      n_fail++;
      $display("FAIL abort: got n=%0d d=%h a=%h expected n=1 d=0001 a=0020", cap.size(),
               (cap.size() > 0) ? cap[0].d : 16'hx, (cap.size() > 0) ? cap[0].a : 16'hx);
    end
  endtask

  task automatic test_idle_err();
    cap.delete();
    drive(1'b0, 1'b1, 16'd77, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (bus.err !== 1'b1 || cap.size() != 0) begin
      n_fail++; $display("FAIL idle_err_set: got err=%b writes=%0d expected err=1 writes=0", bus.err, cap.size());
    end
    arm(16'h0005, 16'd0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_err_clr_n0: got err=%b busy=%b expected err=0 busy=0", bus.err, bus.busy);
    end
    drive(1'b0, 1'b1, 16'd1, 1'b0);
    arm(16'h0006, 16'd1, 1'b0);
    drive(1'b0, 1'b1, 16'd4, 1'b1);
    n_checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL idle_err_clr_start: got err=%b busy=%b expected err=0 busy=1", bus.err, bus.busy);
    end
    repeat (2) drive(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_async_rst();
    cap.delete();
    arm(16'h0040, 16'd2, 1'b0);
    drive(1'b0, 1'b1, 16'd9, 1'b1);
    drive(1'b0, 1'b1, 16'd3, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.dout, bus.dout_addr, bus.unit_we, bus.busy, bus.err} !== 35'h0) begin
      n_fail++;
      $display("FAIL async_rst: got %h expected 0", {bus.dout, bus.dout_addr, bus.unit_we, bus.busy, bus.err});
    end
    drive(1'b0, 1'b1, 16'd50, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (cap.size() != 1 || cap[0].d !== 16'd9 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_nowrite: got n=%0d busy=%b expected n=1 busy=0", cap.size(), bus.busy);
    end
  endtask

  task automatic test_random();
    int w[8];
    int len;
    int n;
    logic [15:0] base;
    bit relu;
    wr_t exp_q[$];
    for (int it = 0; it < 4; it++) begin
      cap.delete();
      exp_q.delete();
      base = 16'($urandom);
      n    = $urandom_range(3, 6);
      relu = 1'($urandom_range(0, 1));
      arm(base, 16'(n), relu);
      for (int k = 0; k < n; k++) begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < 8; i++) w[i] = $signed(16'($urandom));
        exp_q.push_back('{ref_max(w, len, relu), 16'(base + k), (k != n - 1), 0});
        send_window(w, len, 1'b1);
      end
      repeat (2) drive(1'b0, 1'b0, 16'h0, 1'b0);
      n_checks++;
      if (cap.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", it, cap.size(), exp_q.size());
      end else begin
        for (int k = 0; k < n; k++) begin
          n_checks++;
          if (cap[k].d !== exp_q[k].d || cap[k].a !== exp_q[k].a || cap[k].b !== exp_q[k].b) begin
            n_fail++;
            $display("FAIL rand%0d_w%0d: got d=%h a=%h busy=%b expected d=%h a=%h busy=%b", it, k,
                     cap[k].d, cap[k].a, cap[k].b, exp_q[k].d, exp_q[k].a, exp_q[k].b);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_t1();
    test_relu();
    test_back_to_back();
    test_wrap();
    test_abort();
    test_idle_err();
    test_async_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
